// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the round-robin timer arbiter.
package timer_arb_pkg;

  // Engine ownership phases: free, counting for the owner, completion pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of a requester index; never below one bit so a port always exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping past the top index back to zero.
module rr_arbiter
  import timer_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Walk the requests in priority order starting at ptr and keep the first hit.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// One shared up-counting delay engine time-shared among NUM_REQ requesters.
// A granted requester's delay is latched at grant; the counter runs from 0 up
// to that limit, then a one-cycle done pulse is issued and ownership rotates.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SIZE    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ*SIZE-1:0] delay_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic                    busy_o,
  output logic [SIZE-1:0]         count_o
);

  localparam int               IDX_W    = idx_w(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic [SIZE-1:0]  cnt_q;
  logic [SIZE-1:0]  limit_q;
  logic [SIZE-1:0]  delay_arr [NUM_REQ];
  logic             load;
  logic             inc;
  logic             release_owner;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign delay_arr[g] = delay_i[g*SIZE +: SIZE];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req_i),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Priority after a release starts just above the departing owner, wrapping.
  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus datapath strobes; an owner dropping its request wins over
  // the limit compare, so an abort never produces a done pulse.
  always_comb begin
    state_d       = state_q;
    load          = 1'b0;
    inc           = 1'b0;
    release_owner = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = COUNT;
          load    = 1'b1;
        end
      end
      COUNT: begin
        if (!req_i[idx_q]) begin
          state_d       = IDLE;
          release_owner = 1'b1;
        end else if (cnt_q == limit_q) begin
          state_d = DONE;
        end else begin
          inc = 1'b1;
        end
      end
      DONE: begin
        state_d       = IDLE;
        release_owner = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Owner, latched limit, counter and rotating priority pointer. The counter
  // stops at the limit, so it can never wrap even for the all-ones delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      if (load) begin
        idx_q   <= arb_idx;
        limit_q <= delay_arr[arb_idx];
        cnt_q   <= '0;
      end else if (inc) begin
        cnt_q <= cnt_q + SIZE'(1);
      end
      if (release_owner) begin
        ptr_q <= idx_next;
      end
    end
  end

  // Outputs decoded purely from registered state: no input-to-output path.
  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    if (state_q != IDLE) begin
      gnt_o[idx_q] = 1'b1;
    end
    if (state_q == DONE) begin
      done_o[idx_q] = 1'b1;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign count_o = cnt_q;

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_done_owned : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((done_o & ~gnt_o) == '0));
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: a transaction-level model (owner, grant cycle,
// latched delay, priority pointer) predicts every output each cycle, and a
// set of directed scenarios pins exact cycle numbers.
module tb_timer_arbiter;

  localparam int NR = 4;
  localparam int SZ = 16;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [NR-1:0]     req   = '0;
  logic [SZ-1:0]     dly [NR];
  logic [NR*SZ-1:0]  delay_bus;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic              busy;
  logic [SZ-1:0]     count;

  assign delay_bus = {dly[3], dly[2], dly[1], dly[0]};

  always #5 clk = ~clk;

  timer_arbiter #(
    .NUM_REQ (NR),
    .SIZE    (SZ)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .delay_i (delay_bus),
    .gnt_o   (gnt),
    .done_o  (done),
    .busy_o  (busy),
    .count_o (count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // own < 0 means the engine is free. A grant made at the edge closing cycle c
  // owns cycles c+1 .. c+D+2; the last of those carries the done pulse.
  int cyc   = 0;
  int own   = -1;
  int mstart = 0;
  int mlim  = 0;
  int mptr  = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      own  = -1;
      mptr = 0;
    end else begin
      if (own < 0) begin
        for (int k = 0; k < NR; k++) begin
          int j;
          j = (mptr + k) % NR;
          if (own < 0 && req[j]) begin
            own    = j;
            mstart = cyc + 1;
            mlim   = int'(dly[j]);
          end
        end
      end else if ((cyc - mstart == mlim + 1) || !req[own]) begin
        mptr = (own + 1) % NR;
        own  = -1;
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NR-1:0] eg, ed;
  logic          eb;
  int            el;

  initial forever begin
    @(negedge clk);
    eg = '0;
    ed = '0;
    eb = 1'b0;
    el = -1;
    if (rst_n && own >= 0) begin
      eg = 4'b0001 << own;
      eb = 1'b1;
      if (cyc - mstart == mlim + 1) ed = 4'b0001 << own;
      else if (cyc - mstart <= mlim) el = cyc - mstart;
    end
    chk("cyc_gnt", gnt, eg);
    chk("cyc_done", done, ed);
    chk("cyc_busy", busy, eb);
    if (!rst_n) chk("cyc_count_rst", count, 0);
    else if (el >= 0) chk("cyc_count", count, el);
  end

  // ---------------- event monitor ----------------
  int            rise_cyc [NR] = '{default: -1};
  int            fall_cyc [NR] = '{default: -1};
  int            done_cyc [NR] = '{default: -1};
  int            done_cnt [NR] = '{default: 0};
  int            ord_q[$];
  int            ord_cyc_q[$];
  logic [SZ-1:0] cnt_hist [1024];
  logic [NR-1:0] prev_gnt = '0;

  initial forever begin
    @(negedge clk);
    cnt_hist[cyc % 1024] = count;
    for (int i = 0; i < NR; i++) begin
      if (gnt[i] && !prev_gnt[i]) begin
        rise_cyc[i] = cyc;
        ord_q.push_back(i);
        ord_cyc_q.push_back(cyc);
      end
      if (!gnt[i] && prev_gnt[i]) fall_cyc[i] = cyc;
      if (done[i]) begin
        done_cyc[i] = cyc;
        done_cnt[i]++;
      end
    end
    prev_gnt = gnt;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Requesters drop their line when they see their own done pulse.
  task automatic serve(input int bound, input string nm);
    int n;
    n = 0;
    while (n < bound && (req != '0 || busy)) begin
      tick();
      for (int i = 0; i < NR; i++) if (done[i]) req[i] = 1'b0;
      n++;
    end
    if (req != '0 || busy) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t, a, s, n, d0, d1, total;
    for (int i = 0; i < NR; i++) dly[i] = '0;

    // Reset state, asserted between edges.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_gnt", gnt, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_count", count, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single request, delay 5.
    req = 4'b0001; dly[0] = 16'd5; t = cyc; d0 = done_cnt[0];
    serve(40, "single");
    chk("single_gnt_rise", rise_cyc[0], t + 1);
    chk("single_done", done_cyc[0], t + 7);
    chk("single_gnt_fall", fall_cyc[0], t + 8);
    chk("single_done_once", done_cnt[0] - d0, 1);
    chk("single_cnt_first", cnt_hist[(t + 1) % 1024], 0);
    chk("single_cnt_last", cnt_hist[(t + 6) % 1024], 5);

    // Delay 0 on requester 2.
    tick();
    req = 4'b0100; dly[2] = 16'd0; t = cyc;
    serve(20, "zero");
    chk("zero_gnt_rise", rise_cyc[2], t + 1);
    chk("zero_done", done_cyc[2], t + 2);
    chk("zero_gnt_fall", fall_cyc[2], t + 3);

    // Fairness: all four held with delay 3.
    do_reset();
    for (int i = 0; i < NR; i++) dly[i] = 16'd3;
    req = 4'b1111; t = cyc; s = ord_q.size(); n = 0;
    while (n < 100 && ord_q.size() < s + 5) begin
      tick();
      n++;
    end
    req = '0;
    serve(40, "fair_drain");
    if (ord_q.size() >= s + 5) begin
      chk("fair_first_rise", ord_cyc_q[s], t + 1);
      for (int k = 0; k < 5; k++) chk("fair_order", ord_q[s + k], k % NR);
      for (int k = 0; k < 4; k++) chk("fair_spacing", ord_cyc_q[s + k + 1] - ord_cyc_q[s + k], 6);
    end else begin
      chk("fair_grant_count", ord_q.size() - s, 5);
    end

    // Abort: requester 1 drops at count 10, requester 3 pending.
    do_reset();
    dly[1] = 16'd100; dly[3] = 16'd4; req = 4'b1010; d1 = done_cnt[1];
    a = -1; n = 0;
    while (n < 60 && a < 0) begin
      tick();
      if (gnt[1] && count == 16'd10) begin
        req[1] = 1'b0;
        a = cyc;
      end
      n++;
    end
    chk("abort_reached", (a >= 0), 1);
    serve(40, "abort");
    chk("abort_gnt_fall", fall_cyc[1], a + 1);
    chk("abort_next_owner", rise_cyc[3], a + 2);
    chk("abort_no_done", done_cnt[1] - d1, 0);

    // Delay changed mid-count is ignored.
    do_reset();
    req = 4'b0001; dly[0] = 16'd8; t = cyc;
    repeat (3) tick();
    dly[0] = 16'd2;
    serve(40, "dchange");
    chk("dchange_done", done_cyc[0], t + 10);

    // Async reset mid-count, then restart from pointer 0.
    tick();
    req = 4'b0001; dly[0] = 16'd50; d0 = done_cnt[0];
    repeat (5) tick();
    chk("areset_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_gnt", gnt, 0);
    chk("areset_done", done, 0);
    chk("areset_busy", busy, 0);
    chk("areset_count", count, 0);
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    req = 4'b0100; dly[2] = 16'd1; t = cyc;
    serve(20, "areset_after");
    chk("areset_regrant", rise_cyc[2], t + 1);
    chk("areset_regrant_done", done_cyc[2], t + 3);
    chk("areset_no_done0", done_cnt[0] - d0, 0);

    // Randomized traffic with occasional aborts and ignored delay changes.
    do_reset();
    total = 0;
    for (int i = 0; i < NR; i++) total -= done_cnt[i];
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          if (done[i]) req[i] = 1'b0;
          else if (gnt[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
          else if (gnt[i] && $urandom_range(0, 15) == 0) dly[i] = SZ'($urandom_range(0, 20));
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          dly[i] = SZ'($urandom_range(0, 12));
        end
      end
    end
    req = '0;
    serve(100, "rand_drain");
    for (int i = 0; i < NR; i++) total += done_cnt[i];
    chk("rand_activity", (total > 50), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
